// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point add/subtract unit.
package fp_pkg;

  // Sequencer states. The encoding is visible on the unit's debug state output.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Operand classes after unpacking. Denormals are folded into CLS_ZERO.
  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp_class_t;

  // Guard, round and sticky bits carried below the mantissa LSB.
  localparam int GRS_W = 3;

  // Single-precision reference constants. The unit derives its own
  // width-dependent versions from its parameters.
  localparam int                DEF_MANT = 23;
  localparam int                DEF_EXP  = 8;
  localparam int                BIAS     = 2 ** (DEF_EXP - 1) - 1;
  localparam logic [DEF_EXP-1:0] EXP_MAX = '1;
  localparam logic [31:0]       QNAN     = 32'h7FC0_0000;

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero count. An all-zero input yields W.
module leading_zero_counter #(
  parameter int W = 27
) (
  input  logic [W-1:0]             i_data,
  output logic [$clog2(W+1)-1:0]   o_count
);

  localparam int CW = $clog2(W + 1);

  // Scan LSB to MSB so the highest set bit writes last and wins.
  always_comb begin
    o_count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_unit.sv
// Multicycle floating-point add/subtract with round-to-nearest-even,
// flush-to-zero denormals, special-value handling and exception flags.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; operands and op_sub are captured
// on the accepting edge. out_valid stays high, with result and flags frozen,
// until the edge on which out_ready is seen high; the unit then returns to
// IDLE. The producer must not rely on in_valid being seen outside IDLE.
module fp_addsub_unit
  import fp_pkg::*;
#(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int N             = MANTISSA_SIZE + EXPONENT_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [N:0]   a,
  input  logic [N:0]   b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   result,
  output logic         overflow,
  output logic         underflow,
  output logic         invalid,
  output logic         inexact,
  output logic [2:0]   dbg_state
);

  // Working mantissa: hidden bit + fraction + G/R/S.
  localparam int MW = MANTISSA_SIZE + 1 + GRS_W;
  // Exponent with two extra bits so under/overflow never wraps.
  localparam int EW = EXPONENT_SIZE + 2;
  localparam int CW = $clog2(MW + 1);
  localparam logic [EXPONENT_SIZE-1:0] EMAX   = '1;
  localparam logic [EXPONENT_SIZE-1:0] SH_CAP = EXPONENT_SIZE'(MW - 1);
  localparam logic [N:0] CANON_NAN =
    {1'b0, EMAX, 1'b1, {(MANTISSA_SIZE-1){1'b0}}};

  state_t               r_state;
  logic [N:0]           r_a;
  logic [N:0]           r_b;          // sign already flipped for subtract
  logic                 r_sign_l;
  logic                 r_sub;
  logic [EW-1:0]        r_exp;
  logic [MW-1:0]        r_mant_l;
  logic [MW-1:0]        r_mant_s;
  logic [MW:0]          r_sum;
  logic [MW-1:0]        r_mant;
  logic                 r_zero;
  logic [N:0]           r_result;
  logic                 r_out_valid;
  logic                 r_ovf;
  logic                 r_unf;
  logic                 r_inv;
  logic                 r_inx;

  function automatic fp_class_t classify(input logic [EXPONENT_SIZE-1:0] e,
                                         input logic [MANTISSA_SIZE-1:0] f);
    if (e == '0)       return CLS_ZERO;
    else if (e == EMAX) return (f == '0) ? CLS_INF : CLS_NAN;
    else               return CLS_NORMAL;
  endfunction

  // ---------------- unpack / classify (from held operands) ----------------
  logic [EXPONENT_SIZE-1:0] w_ea, w_eb;
  logic [MANTISSA_SIZE-1:0] w_fa, w_fb;
  logic [MANTISSA_SIZE:0]   w_ma, w_mb;
  fp_class_t                w_cls_a, w_cls_b;
  logic                     w_a_larger;

  assign w_ea       = r_a[N-1:MANTISSA_SIZE];
  assign w_eb       = r_b[N-1:MANTISSA_SIZE];
  assign w_fa       = r_a[MANTISSA_SIZE-1:0];
  assign w_fb       = r_b[MANTISSA_SIZE-1:0];
  assign w_ma       = (w_ea == '0) ? '0 : {1'b1, w_fa};
  assign w_mb       = (w_eb == '0) ? '0 : {1'b1, w_fb};
  assign w_cls_a    = classify(w_ea, w_fa);
  assign w_cls_b    = classify(w_eb, w_fb);
  assign w_a_larger = {w_ea, w_ma} >= {w_eb, w_mb};

  // ---------------- alignment ----------------
  logic [EXPONENT_SIZE-1:0] w_el, w_es, w_diff, w_shamt;
  logic [MANTISSA_SIZE:0]   w_ml, w_msm;
  logic                     w_sl;
  logic [MW-1:0]            w_ms_ext, w_ms_shift, w_mask, w_ms_al;
  logic                     w_lost;

  // Order by magnitude and shift the smaller mantissa, folding lost bits into sticky.
  always_comb begin
    w_el       = w_a_larger ? w_ea : w_eb;
    w_es       = w_a_larger ? w_eb : w_ea;
    w_ml       = w_a_larger ? w_ma : w_mb;
    w_msm      = w_a_larger ? w_mb : w_ma;
    w_sl       = w_a_larger ? r_a[N] : r_b[N];
    w_diff     = w_el - w_es;
    w_shamt    = (w_diff > SH_CAP) ? SH_CAP : w_diff;
    w_ms_ext   = {w_msm, {GRS_W{1'b0}}};
    w_ms_shift = w_ms_ext >> w_shamt;
    w_mask     = ~({MW{1'b1}} << w_shamt);
    w_lost     = |(w_ms_ext & w_mask);
    w_ms_al    = {w_ms_shift[MW-1:1], w_ms_shift[0] | w_lost};
  end

  // ---------------- normalisation ----------------
  logic [CW-1:0] w_lz;
  logic [MW-1:0] w_norm_shift;

  leading_zero_counter #(.W(MW)) u_lzc (
    .i_data  (r_sum[MW-1:0]),
    .o_count (w_lz)
  );

  assign w_norm_shift = r_sum[MW-1:0] << w_lz;

  // ---------------- rounding and packing ----------------
  logic                     w_g, w_r, w_s, w_lsb, w_inc;
  logic [MANTISSA_SIZE+1:0] w_rounded;
  logic                     w_rcarry;
  logic [MANTISSA_SIZE-1:0] w_frac;
  logic [EW-1:0]            w_exp_r;
  logic                     w_exp_ovf, w_exp_unf;
  logic                     w_inf_inf;
  logic [N:0]               w_res;
  logic                     w_ovf, w_unf, w_inv, w_inx;

  // Round to nearest even, then pick between special, zero, inf, flushed and normal results.
  always_comb begin
    w_g       = r_mant[GRS_W-1];
    w_r       = r_mant[GRS_W-2];
    w_s       = r_mant[0];
    w_lsb     = r_mant[GRS_W];
    w_inc     = w_g & (w_r | w_s | w_lsb);
    w_rounded = {1'b0, r_mant[MW-1:GRS_W]} + (MANTISSA_SIZE+2)'(w_inc);
    w_rcarry  = w_rounded[MANTISSA_SIZE+1];
    w_frac    = w_rcarry ? w_rounded[MANTISSA_SIZE:1] : w_rounded[MANTISSA_SIZE-1:0];
    w_exp_r   = r_exp + EW'(w_rcarry);
    w_exp_ovf = ~w_exp_r[EW-1] & (w_exp_r[EW-2:0] >= {1'b0, EMAX});
    w_exp_unf = w_exp_r[EW-1] | (w_exp_r == '0);
    w_inf_inf = (w_cls_a == CLS_INF) && (w_cls_b == CLS_INF) && (r_a[N] != r_b[N]);

    w_res = {r_sign_l, w_exp_r[EXPONENT_SIZE-1:0], w_frac};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    w_inx = w_g | w_r | w_s;

    if ((w_cls_a == CLS_NAN) || (w_cls_b == CLS_NAN) || w_inf_inf) begin
      w_res = CANON_NAN;
      w_inv = 1'b1;
      w_inx = 1'b0;
    end else if (w_cls_a == CLS_INF) begin
      w_res = {r_a[N], EMAX, {MANTISSA_SIZE{1'b0}}};
      w_inx = 1'b0;
    end else if (w_cls_b == CLS_INF) begin
      w_res = {r_b[N], EMAX, {MANTISSA_SIZE{1'b0}}};
      w_inx = 1'b0;
    end else if (r_zero) begin
      // Exact cancellation is +0; only an effective add of two -0 stays negative.
      w_res = {(r_sub ? 1'b0 : r_sign_l), {N{1'b0}}};
      w_inx = 1'b0;
    end else if (w_exp_ovf) begin
      w_res = {r_sign_l, EMAX, {MANTISSA_SIZE{1'b0}}};
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else if (w_exp_unf) begin
      w_res = {r_sign_l, {N{1'b0}}};
      w_unf = 1'b1;
      w_inx = 1'b1;
    end
  end

  // ---------------- sequencer and datapath registers ----------------
  // One pass per state; the latency is fixed because every operand takes all states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sign_l    <= 1'b0;
      r_sub       <= 1'b0;
      r_exp       <= '0;
      r_mant_l    <= '0;
      r_mant_s    <= '0;
      r_sum       <= '0;
      r_mant      <= '0;
      r_zero      <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_inv       <= 1'b0;
      r_inx       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= {b[N] ^ op_sub, b[N-1:0]};
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_inv   <= 1'b0;
            r_inx   <= 1'b0;
            r_state <= ALIGN;
          end
        end
        ALIGN: begin
          r_mant_l <= {w_ml, {GRS_W{1'b0}}};
          r_mant_s <= w_ms_al;
          r_exp    <= {2'b00, w_el};
          r_sign_l <= w_sl;
          r_sub    <= r_a[N] ^ r_b[N];
          r_state  <= ADD;
        end
        ADD: begin
          r_sum   <= r_sub ? ({1'b0, r_mant_l} - {1'b0, r_mant_s})
                           : ({1'b0, r_mant_l} + {1'b0, r_mant_s});
          r_state <= NORM;
        end
        NORM: begin
          r_zero <= (r_sum == '0);
          if (r_sum[MW]) begin
            r_mant <= {r_sum[MW:2], r_sum[1] | r_sum[0]};
            r_exp  <= r_exp + EW'(1);
          end else begin
            r_mant <= w_norm_shift;
            r_exp  <= r_exp - EW'(w_lz);
          end
          r_state <= ROUND;
        end
        ROUND: begin
          r_result    <= w_res;
          r_ovf       <= w_ovf;
          r_unf       <= w_unf;
          r_inv       <= w_inv;
          r_inx       <= w_inx;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign invalid   = r_inv;
  assign inexact   = r_inx;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Directed bench for fp_addsub_unit (single-precision defaults).
module tb_fp_addsub_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        invalid;
  logic        inexact;
  logic [2:0]  dbg_state;

  int n_checks;
  int n_err;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd5;

  fp_addsub_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid),
    .inexact   (inexact),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {overflow, underflow, invalid, inexact};
  endfunction

  // ---------------- driver: one full operation with out_ready high ----------------
  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                       input logic tsub, input logic [31:0] exp_res, input logic [3:0] exp_fl);
    int waited;
    int edges;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    a         = ta;
    b         = tb;
    op_sub    = tsub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_lat"}, 64'(edges), 64'd4);
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_flg"}, 64'(flags()), 64'(exp_fl));
    @(posedge clk);
    #1;
    check({tag, "_ret"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int edges;
    int seen_valid;
    n_checks  = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outv",  64'(out_valid), 64'd0);
    check("rst_res",   64'(result),    64'd0);
    check("rst_flg",   64'(flags()),   64'd0);
    check("rst_rdy",   64'(in_ready),  64'd1);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Flags order: {overflow, underflow, invalid, inexact}
    do_op("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4'b0000);
    do_op("mixed_sign",   32'h3FC0_0000, 32'hBF40_0000, 1'b0, 32'h3F40_0000, 4'b0000);
    do_op("cancel",       32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0000);
    do_op("neg_zeros",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b0000);
    do_op("rne_tie",      32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'b0001);
    do_op("rne_up",       32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, 4'b0001);
    do_op("ovf",          32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b1001);
    do_op("inf_m_inf",    32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'b0010);
    do_op("nan_in",       32'h7FC0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b0010);
    do_op("ninf_p_fin",   32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 4'b0000);
    do_op("unf",          32'h0080_0000, 32'h0080_0001, 1'b1, 32'h8000_0000, 4'b0101);

    // ---------------- backpressure ----------------
    @(negedge clk);
    a         = 32'h3FC0_0000;
    b         = 32'hBF40_0000;
    op_sub    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("bp_lat", 64'(edges), 64'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a        = 32'h4000_0000 + 32'(i);
      b        = 32'h3F80_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_res",  64'(result), 64'h3F40_0000);
      check("bp_flg",  64'(flags()), 64'd0);
      check("bp_hs",   64'({out_valid, in_ready}), 64'b10);
      check("bp_st",   64'(dbg_state), 64'(S_DONE));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_exit", 64'({out_valid, in_ready, dbg_state}), 64'({1'b0, 1'b1, S_IDLE}));

    // ---------------- reset during ADD ----------------
    @(negedge clk);
    a        = 32'h3F80_0000;
    b        = 32'h3F80_0000;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_add", 64'(dbg_state), 64'(S_ADD));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_hs",  64'({out_valid, in_ready}), 64'b01);
    check("abort_res", 64'(result), 64'd0);
    check("abort_flg", 64'(flags()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    check("abort_no_result", 64'(seen_valid), 64'd0);
    do_op("after_abort", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_addsub_unit.md
Name: fp_addsub_unit

Overview:
Parametrised multicycle IEEE-754-style floating-point add/subtract unit. It is the successor to the current fixed-sequence adder and adds the following:
- a runtime add/subtract select
- full normalisation, including cancellation
- round-to-nearest-even with guard/round/sticky bits
- special-value handling and exception flags
- valid/ready handshakes on both sides

It sits in the FP ALU datapath between the operand register file and the result writeback mux.

Parameters:
MANTISSA_SIZE, 23, stored fraction bits (hidden bit not stored)
EXPONENT_SIZE, 8, exponent bits, bias = 2^(EXPONENT_SIZE-1)-1
N, MANTISSA_SIZE+EXPONENT_SIZE, MSB index of an encoded word (word width N+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  unit can accept operands
op_sub  in  1  0: a+b, 1: a-b (sampled with operands)
a  in  N+1  operand A {sign, exponent, fraction}
b  in  N+1  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  N+1  encoded result
overflow  out  1  result rounded to ±infinity from finite inputs
underflow  out  1  nonzero result flushed to zero
invalid  out  1  NaN input, or inf - inf
inexact  out  1  any discarded bit was nonzero, or overflow/underflow occurred

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-high, named rst.
  - On reset: state=IDLE, out_valid=0, result=0, all flags=0, in_ready=1 on the next cycle.
  - rst mid-operation aborts the in-flight operation; its result is never presented.
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register a, b (with b's sign XOR op_sub) and go to ALIGN.
  - ALIGN:
    - Unpack and classify each operand: zero/denormal (exp=0, flushed to zero), normal, inf (exp all-ones, frac=0), NaN (exp all-ones, frac≠0).
    - Order operands by magnitude (exponent, then mantissa).
    - Shift the smaller mantissa right by the exponent difference, capped at MANTISSA_SIZE+3. Keep guard, round and sticky (OR of all shifted-out bits).
  - ADD: effective add/subtract on MANTISSA_SIZE+4 bits plus carry; larger - smaller when signs differ. Result sign = sign of the larger operand.
  - NORM:
    - Carry out: shift right 1, fold the LSB into sticky, exponent+1.
    - Otherwise: left-shift by the leading-zero count, exponent -= count.
    - A zero sum gives +0 (RNE sign rule; -0 only when both operands are -0 under effective add).
  - ROUND:
    - Round to nearest even: increment if G&&(R||S||LSB).
    - A mantissa carry renormalises and increments the exponent.
    - Exponent ≥ all-ones → ±inf, overflow=1.
    - Biased exponent ≤ 0 → signed zero, underflow=1.
    - Special cases override here:
      - any NaN → canonical qNaN (sign 0, exp all-ones, frac MSB=1), invalid=1
      - inf - inf → canonical qNaN, invalid=1
      - inf ± finite → that inf
      - inf + inf of same sign → that inf
    - All flags are computed in this state.
  - DONE: out_valid=1. result and flags are held stable until out_valid&&out_ready, then go to IDLE.
- Latency: out_valid rises on the 4th rising edge after the accepting edge. This latency is fixed regardless of operand values, including special cases.
- Throughput: at most one operation per 6 cycles with out_ready held high. in_ready=0 in every state except IDLE.
- Flags are valid only while out_valid=1 and are cleared on the accepting edge of the next operation.
- Exponent arithmetic uses EXPONENT_SIZE+2 signed bits so intermediate under/overflow is detected without wrap-around.

Decomposition:
- fp_pkg holds:
  - state enum
  - BIAS, EXP_MAX (all-ones)
  - canonical qNaN constant
  - classification encodings (ZERO/NORMAL/INF/NAN)
  - GRS width constant (3)
- One sub-module: leading_zero_counter, parametrised width, combinational. Output is the count (width clog2(W+1)); an all-zero input returns W.

Test Plan (defaults 23/8):
1. a=0x3F800000, b=0x3F800000, op_sub=0 → result=0x40000000, out_valid exactly 4 edges after accept, all flags 0.
2. a=0x3FC00000, b=0xBF400000, op_sub=0 → result=0x3F400000. Then a=b=0x3F800000, op_sub=1 → result=0x00000000, flags 0.
3. Rounding:
   - 0x3F800000 + 0x33800000 (tie) → 0x3F800000, inexact=1
   - 0x3F800000 + 0x33C00000 (above half) → 0x3F800001, inexact=1
4. Specials:
   - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1
   - 0x7F800000 - 0x7F800000 → 0x7FC00000, invalid=1
   - 0x7FC00000 + 0x3F800000 → 0x7FC00000, invalid=1
5. Backpressure: hold out_ready=0 for 10 cycles in DONE → result/flags stable, in_ready=0, in_valid pulses ignored. Raise out_ready → IDLE next edge.
6. Assert rst in ADD state → next cycle out_valid=0, result=0, in_ready=1. A new operation (case 1) then completes correctly.
